data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- Parametrised data-memory controller for the multicycle RISC-V core; next generation of the data memory register.
- Byte-addressable word memory of configurable depth.
- Supports full RV32I load/store widths (byte/half/word, signed and unsigned loads).
- Valid/ready request handshake, configurable access latency, misalignment/illegal-op error flag, and sequential zero-initialisation after reset.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, minimum 4.
- LATENCY, 0: extra wait cycles before the access edge; range 0..15.
- IDX_W, $clog2(DEPTH): word-index width; derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 of the load/store.
- req_addr  in  32  byte address from ALU.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse: response fields valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid.

Behaviour:
- States: INIT, IDLE, WAIT, RESP.
- Reset (rst low, async):
  - state=INIT, init_idx=0, wait counter=0, captured request cleared.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
- INIT:
  - Each clock writes 0 to mem[init_idx] and increments init_idx.
  - After the write of index DEPTH-1, go to IDLE.
  - req_ready first rises exactly DEPTH cycles after rst rises.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: capture we, funct3, addr, wdata; cnt=LATENCY; go to WAIT.
  - req_valid while req_ready=0 is ignored; no queuing.
- WAIT:
  - req_ready=0.
  - If cnt!=0: decrement.
  - If cnt==0, at this edge: perform the access, register resp_rdata/resp_err, set resp_valid=1, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Next edge: resp_valid=0, resp_rdata/resp_err hold their values, go to IDLE.
  - The response has no backpressure; the consumer must capture it during the pulse.
- Timing: accept at edge E; resp_valid is high in the cycle after edge E+1+LATENCY; req_ready is high again after edge E+2+LATENCY. One request per 3+LATENCY cycles.
- Indexing: word index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other encoding sets err.
- Misalignment sets err: half access with addr[0]=1; word access with addr[1:0]!=0.
- On err: no memory write; resp_rdata=0; resp_err=1. Timing is identical to a normal access.
- Stores:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes half lane addr[1] with wdata[15:0].
  - SW writes the full word.
  - Unselected bytes are preserved; resp_rdata=0.
- Loads:
  - Select the byte/half lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Data is read at the access edge, so it includes all earlier completed stores.
- Reset mid-operation: an access not yet at its access edge is dropped with no write; the full INIT sweep restarts.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: INIT, IDLE, WAIT, RESP.
- Sub-module dmem_lane_align (combinational): from funct3, addr[1:0], wdata and the read word, produce byte-enables, shifted write data, the extended load result and the err flag.
- The top level holds the FSM, counters and memory array.

Test Plan:
- Init sweep (DEPTH=256): release rst at T, sample req_ready → 0 through T+255, 1 from T+256. LW of 0x3FC → resp_rdata=0x00000000, resp_err=0.
- SW 0x80→0xDEADBEEF, then SB 0x81←0x55 → LW 0x80 = 0xDEAD55EF. LB 0x81 = 0x00000055. LBU 0x83 = 0x000000DE. LH 0x82 = 0xFFFFDEAD. LHU 0x82 = 0x0000DEAD.
- Misaligned and illegal ops:
  - SW to 0x82 → resp_err=1, resp_rdata=0; a later LW 0x80 is unchanged.
  - LH 0x81 → resp_err=1.
  - funct3=011 load → resp_err=1.
- Latency: LATENCY=3, request accepted at edge 10 → resp_valid high only in the cycle after edge 14; req_ready low from after edge 10 until after edge 15; req_valid held high throughout causes no second accept before then.
- Aliasing (DEPTH=16): SW 0x04←0x12345678, then LW 0x44 → 0x12345678.
- Reset mid-WAIT: LATENCY=5, SW accepted, rst pulsed low 2 cycles later → no resp_valid; after re-init, LW of that address = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RV32I load/store
// funct3 encodings, controller states and the wait-counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The wait counter must hold LATENCY values 0..15.
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one load/store. This block decodes the access:
// legality, alignment, store byte-enables, store data replicated onto
// every lane, and the sign/zero-extended load result taken from the
// addressed lane of the word that was read.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] load_data,
    output logic        err
);

    logic [31:0] rword_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        illegal;
    logic        misaligned;

    assign rword_shifted = rword >> {addr_lo, 3'b000};
    assign byte_sel      = rword_shifted[7:0];
    assign half_sel      = addr_lo[1] ? rword[31:16] : rword[15:0];

    // Decode width and signedness, then mask writes and read data on error.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata_sh   = wdata;
        load_data  = 32'h0;
        case (funct3)
            F3_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh   = {2{wdata[15:0]}};
                load_data  = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                misaligned = (addr_lo != 2'b00);
                be         = 4'b1111;
                load_data  = rword;
            end
            F3_BU: begin
                // There is no unsigned store.
                illegal   = we;
                load_data = {24'h0, byte_sel};
            end
            F3_HU: begin
                illegal    = we;
                misaligned = addr_lo[0];
                load_data  = {16'h0, half_sel};
            end
            default: illegal = 1'b1;
        endcase
        err = illegal | misaligned;
        if (err || !we) begin
            be = 4'b0000;
        end
        if (err || we) begin
            load_data = 32'h0;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the multicycle RV32I core: zero-fills the
// memory after reset, then serves one load/store per request through a
// valid/ready handshake with a fixed, parameterised access latency.
// Storage is split into four byte-lane arrays with registered reads.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter  int DEPTH   = 256,
    parameter  int LATENCY = 0,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    state_t             state_reg;
    logic [IDX_W-1:0]   init_idx_reg;
    logic [LAT_W-1:0]   cnt_reg;
    logic               we_reg;
    logic [2:0]         funct3_reg;
    logic [IDX_W+1:0]   addr_reg;
    logic [31:0]        wdata_reg;

    logic [31:0]        rd_word;
    logic [IDX_W-1:0]   rd_idx;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [3:0]         wr_be;
    logic [31:0]        wr_data;

    logic [3:0]         be;
    logic [31:0]        wdata_sh;
    logic [31:0]        load_data;
    logic               err;
    logic               access;

    // Address bits above the memory are ignored, so addresses alias.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign access = (state_reg == WAIT) && (cnt_reg == '0);

    // The read is registered, so it is issued one edge before the access:
    // at the accept edge from the incoming address, afterwards from the
    // captured one. Stores complete well before the next accept, so the
    // word read always reflects every earlier store.
    assign rd_idx = (state_reg == IDLE) ? req_addr[IDX_W+1:2] : addr_reg[IDX_W+1:2];

    dmem_lane_align u_align (
        .we        (we_reg),
        .funct3    (funct3_reg),
        .addr_lo   (addr_reg[1:0]),
        .wdata     (wdata_reg),
        .rword     (rd_word),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .load_data (load_data),
        .err       (err)
    );

    // Single write port shared by the zero-fill sweep and store accesses.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = addr_reg[IDX_W+1:2];
        wr_be   = 4'b0000;
        wr_data = wdata_sh;
        if (state_reg == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = init_idx_reg;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end else if (access) begin
            wr_en = |be;
            wr_be = be;
        end
    end

    // One byte-wide array per lane; per-lane enables give partial stores.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_byte_reg;

        // Byte-lane write with read-before-write registered read.
        always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
                mem[wr_idx] <= wr_data[8*gi +: 8];
            end
            rd_byte_reg <= mem[rd_idx];
        end

        assign rd_word[8*gi +: 8] = rd_byte_reg;
    end

    // Controller FSM: init sweep, request capture, latency wait, response pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= INIT;
            init_idx_reg <= '0;
            cnt_reg      <= '0;
            we_reg       <= 1'b0;
            funct3_reg   <= 3'b000;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
        end else begin
            case (state_reg)
                INIT: begin
                    init_idx_reg <= init_idx_reg + 1'b1;
                    if (init_idx_reg == IDX_W'(DEPTH - 1)) begin
                        state_reg <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr[IDX_W+1:0];
                        wdata_reg  <= req_wdata;
                        cnt_reg    <= LAT_W'(LATENCY);
                        req_ready  <= 1'b0;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        // load_data is already zero for stores and errors.
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= err;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= INIT;
            endcase
        end
    end

endmodule
